// File: rtl/l2_mem_responder.sv
// l2_mem_responder: per-port banked memory with fixed-latency load/store responses.
module l2_mem_responder #(
   parameter int NPORT   = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 9,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NPORT-1:0]          data_req_i,
   input  logic [NPORT*ADDR_W-1:0]   data_add_i,
   input  logic [NPORT-1:0]          data_wen_i,
   input  logic [NPORT*DATA_W-1:0]   data_wdata_i,
   input  logic [NPORT*DATA_W/8-1:0] data_be_i,
   input  logic [NPORT*ID_W-1:0]     data_ID_i,
   output logic [NPORT*DATA_W-1:0]   data_r_rdata_o,
   output logic [NPORT-1:0]          data_r_valid_o,
   output logic [NPORT*ID_W-1:0]     data_r_ID_o
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);

   logic unused_addr;
   assign unused_addr = ^data_add_i;

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      logic [DATA_W-1:0] mem [DEPTH];
      logic [IDX_W-1:0]  idx;
      logic              req, wen;
      logic [ID_W-1:0]   id;
      logic              v_q  [LATENCY];
      logic              w_q  [LATENCY];
      logic [ID_W-1:0]   id_q [LATENCY];
      logic [DATA_W-1:0] d_q  [LATENCY];

      assign idx = data_add_i[p*ADDR_W +: IDX_W];
      assign req = data_req_i[p];
      assign wen = data_wen_i[p];
      assign id  = data_ID_i[p*ID_W +: ID_W];

      // Banks are never reset; requests seen during reset leave them untouched.
      always_ff @(posedge clk) begin
         if (!rst && req && !wen)
            for (int b = 0; b < BE_W; b++)
               if (data_be_i[p*BE_W + b])
                  mem[idx][b*8 +: 8] <= data_wdata_i[p*DATA_W + b*8 +: 8];
      end

      // Fields are zeroed on idle slots so outputs read as 0 whenever valid is low.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
               v_q[s]  <= 1'b0;
               w_q[s]  <= 1'b0;
               id_q[s] <= '0;
               d_q[s]  <= '0;
            end
         end else begin
            v_q[0]  <= req;
            w_q[0]  <= req & wen;
            id_q[0] <= req ? id : '0;
            d_q[0]  <= (req && wen) ? mem[idx] : '0;
            for (int s = 1; s < LATENCY; s++) begin
               v_q[s]  <= v_q[s-1];
               w_q[s]  <= w_q[s-1];
               id_q[s] <= id_q[s-1];
               d_q[s]  <= d_q[s-1];
            end
         end
      end

      assign data_r_valid_o[p]              = v_q[LATENCY-1];
      assign data_r_ID_o[p*ID_W +: ID_W]     = id_q[LATENCY-1];
      assign data_r_rdata_o[p*DATA_W +: DATA_W] = w_q[LATENCY-1] ? d_q[LATENCY-1] : '0;
   end
endmodule

// File: doc/l2_mem_responder.md
L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 Parameter NPORT, default 4: number of independent request ports, one memory bank per port.
REQ-002 Parameter ADDR_W, default 12: word-address width per port.
REQ-003 Parameter DATA_W, default 32: data width; byte-enable width is DATA_W/8.
REQ-004 Parameter ID_W, default 9: transaction ID width.
REQ-005 Parameter DEPTH, default 1024: words per bank, power of two, at most 2^ADDR_W.
REQ-006 Parameter LATENCY, default 1, legal range 1..4: request-to-response delay in cycles.
REQ-007 Port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-008 Port rst, input, 1: reset, synchronous and active-high.
REQ-009 Port data_req_i, input, NPORT: per-port request valid.
REQ-010 Port data_add_i, input, NPORT x ADDR_W: per-port word address.
REQ-011 Port data_wen_i, input, NPORT: per-port direction, 0 = store, 1 = load.
REQ-012 Port data_wdata_i, input, NPORT x DATA_W: per-port store data.
REQ-013 Port data_be_i, input, NPORT x DATA_W/8: per-port byte enables.
REQ-014 Port data_ID_i, input, NPORT x ID_W: per-port request ID.
REQ-015 Port data_r_rdata_o, output, NPORT x DATA_W: per-port response data.
REQ-016 Port data_r_valid_o, output, NPORT: per-port response valid (commit).
REQ-017 Port data_r_ID_o, output, NPORT x ID_W: per-port response ID.

Function
REQ-018 No grant or backpressure: every cycle with data_req_i[p]=1 accepts one request on port p.
REQ-019 Port p accesses only bank p; ports operate independently and in parallel.
REQ-020 Bank index uses data_add_i[p][log2(DEPTH)-1:0]; upper address bits are ignored, so addresses wrap modulo DEPTH.
REQ-021 Store (wen=0): on the acceptance edge, only bytes with be[b]=1 are written into the bank; all other bytes are unchanged.
REQ-022 Load (wen=1): data is read at the acceptance edge; byte enables are ignored, and the full word is returned.
REQ-023 Each accepted request produces exactly one response on the same port: data_r_valid_o[p]=1 for one cycle, exactly LATENCY cycles after acceptance.
REQ-024 data_r_ID_o[p] equals the ID captured at acceptance and is valid in the same cycle as data_r_valid_o[p].
REQ-025 Load response data: data_r_rdata_o[p] = bank word at acceptance time.
REQ-026 Store response data: data_r_rdata_o[p] = 0.
REQ-027 When data_r_valid_o[p]=0, data_r_rdata_o[p] and data_r_ID_o[p] are 0.
REQ-028 Per-port response pipeline: LATENCY-stage shift register of {valid, ID, rdata, wen}.
REQ-029 Throughput: one request per port per cycle; back-to-back requests give back-to-back responses, in order.
REQ-030 Read-after-write: a load accepted in any cycle after a store to the same word returns the stored data.
REQ-031 Store data becomes visible to a load one cycle after the store's acceptance edge.
REQ-032 Bank contents are not reset and persist across rst.
REQ-033 A bench writes each word before reading it.

Reset
REQ-034 While rst=1 at a rising edge, all pipeline stages clear.
REQ-035 From the following cycle, data_r_valid_o, data_r_rdata_o and data_r_ID_o are all 0.
REQ-036 Requests presented while rst=1 are ignored: no bank write and no response.
REQ-037 Reset mid-operation drops all in-flight responses; none appear after rst deasserts.
REQ-038 The first request accepted after rst=0 behaves per REQ-023.

Verification
REQ-039 LATENCY=1, port 0: store addr 0x010, data 0xDEADBEEF, be 0xF, ID 5; then load 0x010, ID 6 -> responses: ID 5 with rdata 0, then ID 6 with rdata 0xDEADBEEF, one cycle after each request.
REQ-040 Partial write: store 0x11223344 be 0xF, then store 0xAABBCCDD be 0x5, then load -> rdata 0x11BB33DD.
REQ-041 All 4 ports in the same cycle issue loads with IDs 1..4 to distinct preloaded words -> all four responses valid in the same cycle, each with correct data and ID.
REQ-042 Wrap-around, DEPTH=1024: store 0x0CAFE at addr 0x405, load addr 0x005 -> rdata 0x0000CAFE.
REQ-043 LATENCY=3: 5 back-to-back loads, IDs 10..14 -> valid high for 5 consecutive cycles starting 3 cycles after the first request, IDs 10..14 in order.
REQ-044 LATENCY=3: assert rst for 1 cycle while 2 responses are in flight -> no valid afterwards; outputs 0; a new request responds after 3 cycles.
